// File: rtl/preset_player.sv
// preset_player
//
// Captures the most recent MIDI channel/system-common message from the
// receive byte stream. A save button event copies it into a preset slot.
// A recall button event replays the slot to the MIDI transmitter over a
// valid/ready handshake.
//
// State table:
//   IDLE | waiting for a button event; capture always runs
//   SEND | replaying a latched slot, one byte per tx_valid&&tx_ready
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-low
//   btn_index  button event (0 = none, 1..NUM_SLOTS = slot), one cycle
//   save_mode  qualifies btn_index as save (1) or recall (0)
//   rx_valid   strobe, rx_byte holds a received MIDI byte
//   rx_byte    received MIDI byte
//   tx_ready   transmitter accepts tx_data this cycle
//   tx_valid   tx_data is valid
//   tx_data    byte being replayed
//   busy       replay in progress
//   saved      one-cycle pulse when a save commits
module preset_player #(
    parameter int NUM_SLOTS = 2,
    parameter int MAX_BYTES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn_index,
    input  logic       save_mode,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       saved
);

    localparam int LW = $clog2(MAX_BYTES + 1);
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [MAX_BYTES-1:0][7:0]   cap_q, cap_d;
    logic [LW-1:0]               cap_len_q, cap_len_d;
    logic [MAX_BYTES-1:0][7:0]   slot_q     [NUM_SLOTS];
    logic [LW-1:0]               slot_len_q [NUM_SLOTS];
    logic [SW-1:0]               rep_slot_q, rep_slot_d;
    logic [LW-1:0]               rep_len_q, rep_len_d;
    logic [LW-1:0]               idx_q, idx_d;
    logic [7:0]                  tx_data_q, tx_data_d;
    logic                        saved_q, saved_d;

    logic          btn_hit;
    logic [SW-1:0] btn_slot;
    logic          save_go;
    logic          recall_go;
    logic [LW-1:0] idx_nxt;

    assign btn_hit   = (btn_index != 2'd0) && (int'(btn_index) <= NUM_SLOTS);
    assign btn_slot  = SW'(btn_index - 2'd1);
    assign save_go   = (state_q == IDLE) && btn_hit && save_mode
                       && (cap_len_q != '0);
    assign recall_go = (state_q == IDLE) && btn_hit && !save_mode
                       && (slot_len_q[btn_slot] != '0);
    assign idx_nxt   = idx_q + LW'(1);

    // Real-time bytes (0xF8..0xFF) may interleave anywhere and never
    // disturb the message being assembled.
    always_comb begin
        cap_d     = cap_q;
        cap_len_d = cap_len_q;
        if (rx_valid) begin
            if (rx_byte[7]) begin
                if (rx_byte < 8'hF8) begin
                    cap_d[0]  = rx_byte;
                    cap_len_d = LW'(1);
                end
            end else if ((cap_len_q != '0) && (cap_len_q < LW'(MAX_BYTES))) begin
                cap_d[cap_len_q] = rx_byte;
                cap_len_d        = cap_len_q + LW'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rep_slot_d = rep_slot_q;
        rep_len_d  = rep_len_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        saved_d    = save_go;
        case (state_q)
            IDLE: begin
                if (recall_go) begin
                    state_d    = SEND;
                    rep_slot_d = btn_slot;
                    rep_len_d  = slot_len_q[btn_slot];
                    idx_d      = '0;
                    tx_data_d  = slot_q[btn_slot][0];
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx_q == rep_len_q - LW'(1)) begin
                        state_d = IDLE;
                    end else begin
                        idx_d     = idx_nxt;
                        tx_data_d = slot_q[rep_slot_q][idx_nxt];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cap_q      <= '0;
            cap_len_q  <= '0;
            rep_slot_q <= '0;
            rep_len_q  <= '0;
            idx_q      <= '0;
            tx_data_q  <= '0;
            saved_q    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_len_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cap_q      <= cap_d;
            cap_len_q  <= cap_len_d;
            rep_slot_q <= rep_slot_d;
            rep_len_q  <= rep_len_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            saved_q    <= saved_d;
            if (save_go) begin
                slot_len_q[btn_slot] <= cap_len_q;
            end
        end
    end

    // Slot bytes are only meaningful below slot_len, so they carry no reset.
    // The save reads cap_q, i.e. the buffer before any same-cycle rx update.
    always_ff @(posedge clk) begin
        if (save_go) begin
            slot_q[btn_slot] <= cap_q;
        end
    end

    assign tx_valid = (state_q == SEND);
    assign busy     = (state_q == SEND);
    assign tx_data  = tx_data_q;
    assign saved    = saved_q;

endmodule

// File: tb/tb_preset_player.sv
module tb_preset_player;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] btn_index = 2'd0;
    logic       save_mode = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'd0;
    logic       tx_ready = 1'b0;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       busy;
    logic       saved;

    preset_player #(.NUM_SLOTS(2), .MAX_BYTES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_index (btn_index),
        .save_mode (save_mode),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .busy      (busy),
        .saved     (saved)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: message-level view of capture, slots and replay.
    logic [7:0] m_cap_b [3];
    int         m_cap_n = 0;
    logic [7:0] m_slot_b [2][3];
    int         m_slot_n [2] = '{0, 0};
    logic [7:0] rep_q [$];
    bit         m_saved = 1'b0;

    always @(posedge clk or negedge rst) begin
        bit was_idle;
        int s;
        if (!rst) begin
            m_cap_n     = 0;
            m_slot_n[0] = 0;
            m_slot_n[1] = 0;
            rep_q.delete();
            m_saved     = 1'b0;
        end else begin
            was_idle = (rep_q.size() == 0);
            m_saved  = 1'b0;
            if (!was_idle && tx_ready) void'(rep_q.pop_front());
            if (was_idle && btn_index >= 2'd1 && btn_index <= 2'd2) begin
                s = int'(btn_index) - 1;
                if (save_mode) begin
                    if (m_cap_n > 0) begin
                        for (int k = 0; k < m_cap_n; k++) m_slot_b[s][k] = m_cap_b[k];
                        m_slot_n[s] = m_cap_n;
                        m_saved     = 1'b1;
                    end
                end else begin
                    for (int k = 0; k < m_slot_n[s]; k++) rep_q.push_back(m_slot_b[s][k]);
                end
            end
            if (rx_valid) begin
                if (rx_byte >= 8'hF8) begin
                    // real-time byte, no effect
                end else if (rx_byte[7]) begin
                    m_cap_b[0] = rx_byte;
                    m_cap_n    = 1;
                end else if (m_cap_n > 0 && m_cap_n < 3) begin
                    m_cap_b[m_cap_n] = rx_byte;
                    m_cap_n++;
                end
            end
        end
    end

    // Per-cycle compare plus a log of accepted bytes for literal checks.
    logic [7:0] log_q [$];
    int busy_cycles = 0;
    int saved_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("tx_valid", {31'd0, tx_valid}, {31'd0, rep_q.size() != 0});
            chk("busy", {31'd0, busy}, {31'd0, rep_q.size() != 0});
            chk("saved", {31'd0, saved}, {31'd0, m_saved});
            if (rep_q.size() != 0) chk("tx_data", {24'd0, tx_data}, {24'd0, rep_q[0]});
            if (tx_valid && tx_ready) log_q.push_back(tx_data);
            if (busy) busy_cycles++;
            if (saved) saved_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic press(input logic [1:0] idx, input logic sm);
        btn_index = idx;
        save_mode = sm;
        tick();
        btn_index = 2'd0;
        save_mode = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic clear_logs();
        log_q.delete();
        busy_cycles = 0;
        saved_cnt   = 0;
    endtask

    initial begin
        logic [7:0] exp3 [3];
        bit         pat [5];

        #12;
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_saved", {31'd0, saved}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Save 0x90 0x3C 0x64 into slot 1
        clear_logs();
        send_rx(8'h90); send_rx(8'h3C); send_rx(8'h64);
        press(2'd1, 1'b1);
        chk("t1_saved_pulse", {31'd0, saved}, 32'd1);
        chk("t1_tx_valid", {31'd0, tx_valid}, 32'd0);
        tick();
        chk("t1_saved_drop", {31'd0, saved}, 32'd0);
        chk("t1_saved_cnt", saved_cnt, 32'd1);

        // Recall slot 1 with tx_ready high
        tx_ready = 1'b1;
        clear_logs();
        chk("t2_pre_valid", {31'd0, tx_valid}, 32'd0);
        press(2'd1, 1'b0);
        chk("t2_first_valid", {31'd0, tx_valid}, 32'd1);
        chk("t2_first_data", {24'd0, tx_data}, 32'h90);
        wait_idle(10);
        tick();
        exp3 = '{8'h90, 8'h3C, 8'h64};
        chk("t2_len", log_q.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < log_q.size()) chk("t2_byte", {24'd0, log_q[i]}, {24'd0, exp3[i]});
        chk("t2_busy_cycles", busy_cycles, 32'd3);

        // Slot 2 = 0xC0 0x05, recall with ready pattern 1,0,0,1,1
        send_rx(8'hC0); send_rx(8'h05);
        press(2'd2, 1'b1);
        tick();
        clear_logs();
        press(2'd2, 1'b0);
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            tx_ready = pat[i];
            if (i == 3) chk("t3_held", {24'd0, tx_data}, 32'h05);
            tick();
        end
        tx_ready = 1'b1;
        wait_idle(10);
        tick();
        chk("t3_len", log_q.size(), 32'd2);
        if (log_q.size() == 2) begin
            chk("t3_b0", {24'd0, log_q[0]}, 32'hC0);
            chk("t3_b1", {24'd0, log_q[1]}, 32'h05);
        end

        // Overlong message plus real-time byte, save slot 1
        send_rx(8'hB0); send_rx(8'h07); send_rx(8'h7F); send_rx(8'h10); send_rx(8'hF8);
        press(2'd1, 1'b1);
        tick();
        clear_logs();
        press(2'd1, 1'b0);
        wait_idle(10);
        tick();
        exp3 = '{8'hB0, 8'h07, 8'h7F};
        chk("t4_len", log_q.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < log_q.size()) chk("t4_byte", {24'd0, log_q[i]}, {24'd0, exp3[i]});

        // Button events during SEND are ignored
        clear_logs();
        tx_ready = 1'b0;
        send_rx(8'h91);
        press(2'd1, 1'b0);
        press(2'd2, 1'b1);
        press(2'd2, 1'b0);
        tick();
        tx_ready = 1'b1;
        wait_idle(10);
        tick(); tick();
        chk("t5_saved_cnt", saved_cnt, 32'd0);
        chk("t5_len", log_q.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < log_q.size()) chk("t5_byte", {24'd0, log_q[i]}, {24'd0, exp3[i]});
        clear_logs();
        press(2'd2, 1'b0);
        wait_idle(10);
        tick();
        chk("t5_slot2_len", log_q.size(), 32'd2);
        if (log_q.size() == 2) begin
            chk("t5_slot2_b0", {24'd0, log_q[0]}, 32'hC0);
            chk("t5_slot2_b1", {24'd0, log_q[1]}, 32'h05);
        end

        // Out-of-range button has no effect
        clear_logs();
        press(2'd3, 1'b0);
        press(2'd3, 1'b1);
        tick();
        chk("t6_busy_cycles", busy_cycles, 32'd0);
        chk("t6_saved_cnt", saved_cnt, 32'd0);

        // Reset mid-replay
        press(2'd1, 1'b0);
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("t7_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("t7_busy", {31'd0, busy}, 32'd0);
        chk("t7_saved", {31'd0, saved}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        clear_logs();
        press(2'd1, 1'b0);
        tick(); tick();
        chk("t7_no_replay", busy_cycles, 32'd0);

        // Data byte without status cannot be saved
        send_rx(8'h40);
        press(2'd1, 1'b1);
        tick();
        chk("t8_saved_cnt", saved_cnt, 32'd0);
        press(2'd1, 1'b0);
        tick(); tick();
        chk("t8_no_replay", busy_cycles, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/preset_player.md
Name: preset_player

Overview:
- Sits directly downstream of the button decoder.
- Consumes its one-cycle btn_index/save_mode events and the byte stream from the MIDI receive parser.
- Continuously captures the most recent MIDI channel/system-common message into a capture buffer.
- A save event copies that message into the preset slot chosen by the button; a recall event replays the slot's bytes to the MIDI transmitter over a valid/ready handshake.

Parameters:
- NUM_SLOTS, 2, number of preset slots; slot = btn_index-1; btn_index values above NUM_SLOTS are ignored.
- MAX_BYTES, 3, maximum stored message length in bytes (status plus data).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- btn_index  input  2  button event; 0 = none, 1..NUM_SLOTS = slot select; valid for one cycle
- save_mode  input  1  qualifies a btn_index event as save (1) or recall (0)
- rx_valid  input  1  one-cycle strobe, rx_byte carries a received MIDI byte
- rx_byte  input  8  received MIDI byte
- tx_ready  input  1  transmitter can accept a byte this cycle
- tx_valid  output  1  tx_data is valid
- tx_data  output  8  byte to transmit
- busy  output  1  replay in progress
- saved  output  1  one-cycle pulse when a save commits

Behaviour:
- Reset (rst low, asynchronous):
  - tx_valid=0, tx_data=0, busy=0, saved=0.
  - Capture buffer emptied: cap_len=0.
  - All slot lengths =0. Slot byte contents are don't-care.
  - FSM enters IDLE.
- Capture, on rx_valid:
  - 0xF8..0xFF (real-time): ignored; capture state unchanged.
  - Other byte with bit7=1 (status): cap[0]<=byte, cap_len<=1.
  - Data byte with cap_len==0: dropped. Running status is not supported.
  - Data byte with 0<cap_len<MAX_BYTES: cap[cap_len]<=byte, cap_len++.
  - Data byte with cap_len==MAX_BYTES: dropped; buffer stays unchanged until the next status byte.
- Save: btn_index in 1..NUM_SLOTS, save_mode=1, FSM IDLE.
  - If cap_len!=0: slot bytes<=cap, slot_len<=cap_len, saved=1 on the next cycle.
  - If cap_len==0: no write, no saved pulse.
  - When rx_valid coincides with the save event, the save copies the pre-update buffer; the rx byte still updates the capture buffer.
- Recall: btn_index in 1..NUM_SLOTS, save_mode=0, FSM IDLE.
  - slot_len==0: no action.
  - Otherwise, FSM goes to SEND; cycle N+1 after the event: tx_valid=1, tx_data=slot[0], busy=1, idx=0.
- FSM:
  - IDLE -> SEND on a recall event with nonzero slot length.
  - SEND, on each cycle with tx_valid&&tx_ready: byte accepted.
    - If idx==len-1: next cycle tx_valid=0, busy=0, return to IDLE.
    - Otherwise idx++ and tx_data=slot[idx] on the next cycle; consecutive bytes are back-to-back.
  - SEND, tx_ready low: tx_valid and tx_data held stable; no byte skipped or repeated.
  - Any btn_index event (save or recall) while in SEND is ignored and not queued.
- Replay uses a latched slot index and length. Capture continues during SEND and does not affect an ongoing replay.
- Reset asserted mid-SEND: tx_valid drops immediately (asynchronous); the partial message is not resumed.
- btn_index==0, or btn_index>NUM_SLOTS: no effect.

Test Plan:
- Bytes 0x90,0x3C,0x64 on rx, then btn_index=1, save_mode=1 -> saved pulses one cycle later; tx_valid stays 0.
- After the save above, btn_index=1, save_mode=0, tx_ready=1 -> tx_data 0x90,0x3C,0x64 on three consecutive cycles starting at N+1; busy high for exactly 3 cycles.
- Recall slot 2 with tx_ready toggling 1,0,0,1,1 after storing 0xC0,0x05 -> each byte held while ready is low; output sequence exactly 0xC0,0x05; no duplicates.
- Capture edge cases:
  - Rx 0xB0,0x07,0x7F,0x10 then 0xF8, then save slot 1 -> stored length 3, bytes 0xB0,0x07,0x7F.
  - Rx 0x40 with no prior status, then save -> no saved pulse; slot length unchanged.
- During SEND, pulse btn_index=2 with save_mode=1 and with save_mode=0 -> slot 2 unchanged, no saved pulse, replay of slot 1 completes unaltered.
- Assert rst low mid-replay -> tx_valid, busy, saved = 0 immediately. After release, recall slot 1 -> no output (slot lengths cleared).
